// File: rtl/imm_ext_pkg.sv
// Shared types and parameter-legality constants for the immediate-extension stage.
// Build option: define IMM_EXT_SHIFT_EN to make BROFF and UPPER modes legal.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_SEXT  = 2'd0,
    IMM_ZEXT  = 2'd1,
    IMM_BROFF = 2'd2,
    IMM_UPPER = 2'd3
  } imm_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  localparam int MIN_IN_W     = 2;
  localparam int MIN_BR_SHIFT = 0;

  // The branch shift must leave the shifted sign-extended value meaningful.
  function automatic bit params_legal(input int in_w, input int out_w, input int br_shift);
    return (in_w >= MIN_IN_W) && (in_w < out_w) &&
           (br_shift >= MIN_BR_SHIFT) && (br_shift < (out_w - in_w));
  endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: maps a raw immediate and mode to an operand plus error bit.
// Build option: IMM_EXT_SHIFT_EN enables BROFF/UPPER; otherwise they fall back to SEXT with err set.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  imm_i,
  input  logic [1:0]       mode_i,
  output logic [OUT_W-1:0] data_o,
  output logic             err_o
);

  logic [OUT_W-1:0] sext_val;
  logic [OUT_W-1:0] zext_val;

  assign sext_val = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};
  assign zext_val = {{(OUT_W-IN_W){1'b0}}, imm_i};

`ifdef IMM_EXT_SHIFT_EN
  logic [OUT_W-1:0] broff_val;
  logic [OUT_W-1:0] upper_val;

  assign broff_val = sext_val << BR_SHIFT;
  assign upper_val = {imm_i, {(OUT_W-IN_W){1'b0}}};
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    data_o = sext_val;
    err_o  = 1'b0;
    case (imm_mode_e'(mode_i))
      IMM_SEXT:  data_o = sext_val;
      IMM_ZEXT:  data_o = zext_val;
`ifdef IMM_EXT_SHIFT_EN
      IMM_BROFF: data_o = broff_val;
      IMM_UPPER: data_o = upper_val;
`else
      IMM_BROFF, IMM_UPPER: err_o = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate-extension stage with a two-entry skid buffer and registered in_ready.
// Build option: IMM_EXT_SHIFT_EN (see imm_ext_core) selects which modes are legal.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
);

  if (!params_legal(IN_W, OUT_W, BR_SHIFT)) begin : g_bad_params
    $error("imm_extend_unit: illegal IN_W/OUT_W/BR_SHIFT combination");
  end

  occ_state_e       state_q;
  logic [OUT_W-1:0] main_data_q, skid_data_q;
  logic             main_err_q, skid_err_q;
  logic             out_valid_q, in_ready_q;
  logic [OUT_W-1:0] ext_data_d;
  logic             ext_err_d;
  logic             in_fire, out_fire;

  imm_ext_core #(
    .IN_W    (IN_W),
    .OUT_W   (OUT_W),
    .BR_SHIFT(BR_SHIFT)
  ) u_core (
    .imm_i (in_imm),
    .mode_i(in_mode),
    .data_o(ext_data_d),
    .err_o (ext_err_d)
  );

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, since out_data must read zero after reset.
      state_q     <= OCC_EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            main_data_q <= ext_data_d;
            main_err_q  <= ext_err_d;
            out_valid_q <= 1'b1;
            state_q     <= OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (in_fire && !out_fire) begin
            skid_data_q <= ext_data_d;
            skid_err_q  <= ext_err_d;
            in_ready_q  <= 1'b0;
            state_q     <= OCC_FULL;
          end else if (out_fire && !in_fire) begin
            out_valid_q <= 1'b0;
            state_q     <= OCC_EMPTY;
          end else if (in_fire && out_fire) begin
            main_data_q <= ext_data_d;
            main_err_q  <= ext_err_d;
          end
        end
        OCC_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (out_fire) begin
            main_data_q <= skid_data_q;
            main_err_q  <= skid_err_q;
            in_ready_q  <= 1'b1;
            state_q     <= OCC_ONE;
          end
        end
        default: state_q <= OCC_EMPTY;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_imm_extend_unit.sv
// Self-checking bench for imm_extend_unit: vector table, backpressure, streaming, random and reset cases.
// Expected values follow IMM_EXT_SHIFT_EN in the same way as the design build.
module tb_imm_extend_unit;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  mode;
    logic [31:0] data;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int   checks = 0;
  int   passes = 0;
  exp_t sb[$];
  bit   rand_active;

  imm_extend_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_imm   (in_imm),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  function automatic exp_t model(input logic [15:0] imm, input logic [1:0] mode);
    exp_t e;
    logic signed [31:0] s;
    s = $signed(imm);
    e.err = 1'b0;
    case (mode)
      2'd0: e.data = s;
      2'd1: e.data = {16'h0000, imm};
`ifdef IMM_EXT_SHIFT_EN
      2'd2: e.data = s * 4;
      default: e.data = {imm, 16'h0000};
`else
      default: begin e.data = s; e.err = 1'b1; end
`endif
    endcase
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the accepting edge with in_valid low.
  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [31:0] ed, input logic ee);
    exp_t e;
    bit   done = 0;
    in_imm   = imm;
    in_mode  = mode;
    in_valid = 1'b1;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.data = ed;
        e.err  = ee;
        sb.push_back(e);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) break;
    end
    check("drain_empty", sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop on every output transfer, and hold check while stalled.
  initial begin
    bit          prev_stall = 0;
    logic [31:0] prev_data  = '0;
    logic        prev_err   = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", out_data, prev_data);
          check("hold_err", 32'(out_err), 32'(prev_err));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output", sb.size(), 32'd1);
          end else begin
            e = sb.pop_front();
            check("sb_data", out_data, e.data);
            check("sb_err", 32'(out_err), 32'(e.err));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_err   = out_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    exp_t e;

    vecs[0] = '{16'h8001, 2'd0, 32'hFFFF8001, 1'b0};
    vecs[1] = '{16'hFFFE, 2'd1, 32'h0000FFFE, 1'b0};
`ifdef IMM_EXT_SHIFT_EN
    vecs[2] = '{16'hFFFE, 2'd2, 32'hFFFFFFF8, 1'b0};
    vecs[3] = '{16'hFFFE, 2'd3, 32'hFFFE0000, 1'b0};
    vecs[6] = '{16'h4001, 2'd2, 32'h00010004, 1'b0};
    vecs[7] = '{16'h1234, 2'd3, 32'h12340000, 1'b0};
`else
    vecs[2] = '{16'hFFFE, 2'd2, 32'hFFFFFFFE, 1'b1};
    vecs[3] = '{16'hFFFE, 2'd3, 32'hFFFFFFFE, 1'b1};
    vecs[6] = '{16'h4001, 2'd2, 32'h00004001, 1'b1};
    vecs[7] = '{16'h1234, 2'd3, 32'h00001234, 1'b1};
`endif
    vecs[4] = '{16'h7FFF, 2'd0, 32'h00007FFF, 1'b0};
    vecs[5] = '{16'h8000, 2'd1, 32'h00008000, 1'b0};
    vecs[8] = '{16'h0000, 2'd0, 32'h00000000, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // First word: one-cycle latency from the accepting edge.
    out_ready = 1'b1;
    send(16'h8001, 2'd0, 32'hFFFF8001, 1'b0);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", out_data, 32'hFFFF8001);
    check("lat_out_err", 32'(out_err), 32'd0);
    drain();

    for (int i = 0; i < 9; i++) send(vecs[i].imm, vecs[i].mode, vecs[i].data, vecs[i].err);
    drain();

    // Backpressure: 1 and 2 fill main+skid, 3 waits until the stall is released.
    out_ready = 1'b0;
    send(16'd1, 2'd0, 32'd1, 1'b0);
    send(16'd2, 2'd0, 32'd2, 1'b0);
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_out_data", out_data, 32'd1);
    fork
      send(16'd3, 2'd0, 32'd3, 1'b0);
      begin
        int n = 0;
        repeat (2) begin
          @(negedge clk);
          check("bp_hold_data", out_data, 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          if (out_valid) n++;
          else break;
        end
        check("bp_no_gap_count", 32'(n), 32'd3);
      end
    join
    drain();

    // Continuous stream of 100 words with the sink always ready.
    fork
      for (int i = 0; i < 100; i++) send(16'(i + 16'h7FC0), 2'(i % 2), model(16'(i + 16'h7FC0), 2'(i % 2)).data, 1'b0);
      begin
        int n = 0;
        bit dropped = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (in_valid && in_ready) break;
        end
        @(negedge clk);
        check("stream_latency", 32'(out_valid), 32'd1);
        n = out_valid ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
          @(negedge clk);
          if (in_valid && !in_ready) dropped = 1;
          if (out_valid) n++;
          else break;
        end
        check("stream_count", 32'(n), 32'd100);
        check("stream_in_ready_kept", 32'(dropped), 32'd0);
      end
    join
    drain();

    // Random words with random sink stalls and random source gaps.
    rand_active = 1;
    fork
      begin
        logic [15:0] imm;
        logic [1:0]  mode;
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          imm  = 16'($urandom);
          mode = 2'($urandom_range(0, 3));
          e    = model(imm, mode);
          send(imm, mode, e.data, e.err);
        end
        rand_active = 0;
      end
      while (rand_active) begin
        @(posedge clk);
        #1;
        out_ready = 1'($urandom_range(0, 1));
      end
    join
    out_ready = 1'b1;
    drain();

    // Asynchronous reset while FULL discards both held words.
    out_ready = 1'b0;
    send(16'hAAAA, 2'd1, 32'h0000AAAA, 1'b0);
    send(16'hBBBB, 2'd1, 32'h0000BBBB, 1'b0);
    check("full_in_ready_low", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_data", out_data, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'(16'hF000 + i), 2'd0, model(16'(16'hF000 + i), 2'd0).data, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
